// File: rtl/l3_mem_target_if.sv
// L2-to-L3 command bus: command fields, write/read data streams and status return.
// Master is the L2 side; slave is the memory target.
interface l3_mem_target_if;
   logic        l3_en;
   logic [3:0]  l3_sel;
   logic [3:0]  l3_id;
   logic [7:0]  l3_op;
   logic [15:0] l3_size;
   logic [15:0] l3_extend;
   logic [31:0] l3_wd;
   logic        l3_wd_vld;
   logic        l3_wd_rdy;
   logic [31:0] l3_rd;
   logic        l3_rd_vld;
   logic        l3_rd_rdy;
   logic [7:0]  resp;
   logic        resp_vld;
   logic        resp_rdy;

   modport master (
      output l3_en, l3_sel, l3_id, l3_op, l3_size, l3_extend,
      output l3_wd, l3_wd_vld, l3_rd_rdy, resp_rdy,
      input  l3_wd_rdy, l3_rd, l3_rd_vld, resp, resp_vld
   );

   modport slave (
      input  l3_en, l3_sel, l3_id, l3_op, l3_size, l3_extend,
      input  l3_wd, l3_wd_vld, l3_rd_rdy, resp_rdy,
      output l3_wd_rdy, l3_rd, l3_rd_vld, resp, resp_vld
   );
endinterface

// File: rtl/l3_mem_target.sv
// L3 memory target: word-burst writes/reads into a local register file, one status byte per command.
// One-cycle decode, then one word per cycle; every output stream holds until its ready.
module l3_mem_target #(
   parameter logic [3:0] SEL_ID = 4'h0,
   parameter int         AW     = 8,
   parameter logic [7:0] OP_WR  = 8'h01,
   parameter logic [7:0] OP_RD  = 8'h02
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           pin_l2_clr,
   l3_mem_target_if.slave l3
);
   typedef enum logic [2:0] {IDLE, DEC, WR, RD, RSP, DONE} state_t;

   localparam logic [16:0] DEPTH = 17'd1 << AW;

   state_t      state;
   logic [7:0]  op_q;
   logic [3:0]  id_q;
   logic [AW-1:0] ptr;
   logic [15:0] cnt;
   logic [31:0] mem [2**AW];
   logic [16:0] end_addr;
   logic        wr_fire;
   logic        unused_ext;

   assign unused_ext = ^l3.l3_extend;
   assign end_addr   = 17'(ptr) + 17'(cnt);

   // An aborting or clearing cycle must not commit the word on the bus.
   assign wr_fire = (state == WR) && l3.l3_en && l3.l3_wd_vld && l3.l3_wd_rdy &&
                    !rst && !pin_l2_clr;

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[ptr] <= l3.l3_wd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || pin_l2_clr) begin
         state        <= IDLE;
         op_q         <= '0;
         id_q         <= '0;
         ptr          <= '0;
         cnt          <= '0;
         l3.l3_wd_rdy <= 1'b0;
         l3.l3_rd_vld <= 1'b0;
         l3.l3_rd     <= '0;
         l3.resp_vld  <= 1'b0;
         l3.resp      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (l3.l3_en && l3.l3_sel == SEL_ID) begin
                  op_q  <= l3.l3_op;
                  id_q  <= l3.l3_id;
                  ptr   <= l3.l3_extend[AW-1:0];
                  cnt   <= l3.l3_size;
                  state <= DEC;
               end
            end
            DEC: begin
               if (!l3.l3_en) begin
                  state <= IDLE;
               end else if (op_q != OP_WR && op_q != OP_RD) begin
                  state       <= RSP;
                  l3.resp_vld <= 1'b1;
                  l3.resp     <= {id_q, 4'h1};
               end else if (cnt == 16'd0) begin
                  state       <= RSP;
                  l3.resp_vld <= 1'b1;
                  l3.resp     <= {id_q, 4'h0};
               end else if (end_addr > DEPTH) begin
                  state       <= RSP;
                  l3.resp_vld <= 1'b1;
                  l3.resp     <= {id_q, 4'h2};
               end else if (op_q == OP_WR) begin
                  state        <= WR;
                  l3.l3_wd_rdy <= 1'b1;
               end else begin
                  state <= RD;
               end
            end
            WR: begin
               if (!l3.l3_en) begin
                  state        <= IDLE;
                  l3.l3_wd_rdy <= 1'b0;
               end else if (l3.l3_wd_vld && l3.l3_wd_rdy) begin
                  ptr <= ptr + AW'(1);
                  cnt <= cnt - 16'd1;
                  if (cnt == 16'd1) begin
                     l3.l3_wd_rdy <= 1'b0;
                     state        <= RSP;
                     l3.resp_vld  <= 1'b1;
                     l3.resp      <= {id_q, 4'h0};
                  end
               end
            end
            RD: begin
               if (!l3.l3_en) begin
                  state        <= IDLE;
                  l3.l3_rd_vld <= 1'b0;
               end else if (cnt != 16'd0 && (!l3.l3_rd_vld || l3.l3_rd_rdy)) begin
                  // Refill the output register in the same cycle the previous word leaves.
                  l3.l3_rd     <= mem[ptr];
                  l3.l3_rd_vld <= 1'b1;
                  ptr          <= ptr + AW'(1);
                  cnt          <= cnt - 16'd1;
               end else if (l3.l3_rd_vld && l3.l3_rd_rdy) begin
                  l3.l3_rd_vld <= 1'b0;
                  state        <= RSP;
                  l3.resp_vld  <= 1'b1;
                  l3.resp      <= {id_q, 4'h0};
               end
            end
            RSP: begin
               if (l3.resp_rdy) begin
                  l3.resp_vld <= 1'b0;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (!l3.l3_en) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_l3_mem_target.sv
// Bench for l3_mem_target: table of directed commands, hand-written abort/clear/reset
// sequences, then random commands checked against a plain-array memory model.
module tb_l3_mem_target;
   logic clk = 1'b0;
   logic rst;
   logic clr;
   always #5 clk = ~clk;

   l3_mem_target_if b ();
   l3_mem_target dut (.clk(clk), .rst(rst), .pin_l2_clr(clr), .l3(b));

   int n_vec = 0;
   int n_err = 0;
   int stall_err = 0;
   int n_wrdy, n_rvld, first_acc, last_acc;
   logic [31:0] ref_mem [256];
   logic [31:0] wq[$];
   logic [31:0] rq[$];
   bit pat [5];

   typedef struct {
      logic [3:0]  sel;
      logic [3:0]  id;
      logic [7:0]  op;
      logic [15:0] size;
      logic [15:0] ext;
      int          rdy_mode;
      logic        exp_got;
      logic [7:0]  exp_resp;
   } vec_t;
   vec_t tbl [9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [3:0] exp_code(input logic [7:0] op, input logic [15:0] size,
                                           input logic [15:0] ext);
      if (op != 8'h01 && op != 8'h02) return 4'h1;
      if (size == 16'd0) return 4'h0;
      if (int'(ext[7:0]) + int'(size) > 256) return 4'h2;
      return 4'h0;
   endfunction

   // Drives one command from a negedge; returns at a negedge. rdy_mode 0: always ready,
   // 1: random, 2: pattern indexed by cycles that rd_vld has been high.
   task automatic do_cmd(input logic [3:0] sel, input logic [3:0] id, input logic [7:0] op,
                         input logic [15:0] size, input logic [15:0] ext, input int rdy_mode,
                         input int max_cyc, input bit keep_en,
                         output logic got, output logic [7:0] rv);
      int wi, pc;
      logic pstall;
      logic [31:0] prd;
      got = 1'b0; rv = '0; wi = 0; pc = 0; pstall = 1'b0; prd = '0;
      rq.delete(); n_wrdy = 0; n_rvld = 0; first_acc = -1; last_acc = -1;
      b.l3_sel = sel; b.l3_id = id; b.l3_op = op; b.l3_size = size; b.l3_extend = ext;
      b.l3_en = 1'b1; b.resp_rdy = 1'b1;
      for (int c = 0; c < max_cyc && !got; c++) begin
         if (pstall && (b.l3_rd_vld !== 1'b1 || b.l3_rd !== prd)) stall_err++;
         b.l3_wd_vld = (wi < wq.size());
         b.l3_wd     = b.l3_wd_vld ? wq[wi] : 32'h0;
         if (rdy_mode == 0)      b.l3_rd_rdy = 1'b1;
         else if (rdy_mode == 1) b.l3_rd_rdy = 1'($urandom_range(0, 1));
         else                    b.l3_rd_rdy = (pc < 5) ? pat[pc] : 1'b1;
         if (b.l3_rd_vld) pc++;
         if (b.l3_wd_rdy) n_wrdy++;
         if (b.l3_rd_vld) n_rvld++;
         if (b.l3_wd_vld && b.l3_wd_rdy) wi++;
         if (b.l3_rd_vld && b.l3_rd_rdy) begin
            rq.push_back(b.l3_rd);
            if (first_acc < 0) first_acc = c;
            last_acc = c;
         end
         if (b.resp_vld && b.resp_rdy) begin
            got = 1'b1;
            rv  = b.resp;
         end
         pstall = b.l3_rd_vld && !b.l3_rd_rdy;
         prd    = b.l3_rd;
         @(negedge clk);
      end
      if (!keep_en) begin
         b.l3_en = 1'b0; b.l3_wd_vld = 1'b0; b.l3_rd_rdy = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic run_check(input string nm, input logic [3:0] sel, input logic [3:0] id,
                            input logic [7:0] op, input logic [15:0] size, input logic [15:0] ext,
                            input int rdy_mode, input logic exp_got, input logic [7:0] exp_resp);
      logic got;
      logic [7:0] rv;
      logic [31:0] exp_q[$];
      int base;
      bit ok_cmd;
      base   = int'(ext[7:0]);
      ok_cmd = (sel == 4'h0) && (exp_code(op, size, ext) == 4'h0) && (size != 16'd0);
      if (ok_cmd && op == 8'h02)
         for (int i = 0; i < int'(size); i++) exp_q.push_back(ref_mem[(base + i) % 256]);
      do_cmd(sel, id, op, size, ext, rdy_mode, 64 + 8 * int'(size), 1'b0, got, rv);
      chk({nm, " resp seen"}, 32'(got), 32'(exp_got));
      if (exp_got) chk({nm, " resp"}, 32'(rv), 32'(exp_resp));
      chk({nm, " wd_rdy cycles"}, n_wrdy, (ok_cmd && op == 8'h01) ? 32'(size) : 32'd0);
      if (ok_cmd && op == 8'h02) begin
         chk({nm, " read count"}, rq.size(), 32'(size));
         for (int i = 0; i < rq.size() && i < exp_q.size(); i++)
            chk($sformatf("%s word%0d", nm, i), rq[i], exp_q[i]);
         if (rdy_mode == 0) chk({nm, " read span"}, last_acc - first_acc, 32'(size) - 1);
      end else begin
         chk({nm, " rd_vld cycles"}, n_rvld, 0);
      end
      if (ok_cmd && op == 8'h01)
         for (int i = 0; i < int'(size); i++) ref_mem[(base + i) % 256] = wq[i];
   endtask

   initial begin
      logic got, seen;
      logic [7:0] rv;
      logic [3:0] sel, id, code;
      logic [7:0] op;
      logic [15:0] size, ext;
      int wi;

      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[0] = '{4'h0, 4'h3, 8'h01, 16'd4, 16'h0010, 0, 1'b1, 8'h30};
      tbl[1] = '{4'h0, 4'h3, 8'h02, 16'd4, 16'h0010, 0, 1'b1, 8'h30};
      tbl[2] = '{4'h0, 4'h6, 8'h02, 16'd3, 16'h0010, 2, 1'b1, 8'h60};
      tbl[3] = '{4'h0, 4'h7, 8'h55, 16'd4, 16'h0020, 0, 1'b1, 8'h71};
      tbl[4] = '{4'h0, 4'h9, 8'h01, 16'd3, 16'h00FE, 0, 1'b1, 8'h92};
      tbl[5] = '{4'h0, 4'h4, 8'h02, 16'd0, 16'h0000, 0, 1'b1, 8'h40};
      tbl[6] = '{4'h5, 4'h2, 8'h01, 16'd2, 16'h0030, 0, 1'b0, 8'h00};
      tbl[7] = '{4'h0, 4'h2, 8'h02, 16'd3, 16'h00FD, 0, 1'b1, 8'h20};
      tbl[8] = '{4'h0, 4'h1, 8'h01, 16'd1, 16'h00FF, 0, 1'b1, 8'h10};

      rst = 1'b1; clr = 1'b0;
      b.l3_en = 1'b0; b.l3_sel = '0; b.l3_id = '0; b.l3_op = '0; b.l3_size = '0;
      b.l3_extend = '0; b.l3_wd = '0; b.l3_wd_vld = 1'b0; b.l3_rd_rdy = 1'b0; b.resp_rdy = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset wd_rdy", 32'(b.l3_wd_rdy), 0);
      chk("reset rd_vld", 32'(b.l3_rd_vld), 0);
      chk("reset rd", b.l3_rd, 0);
      chk("reset resp_vld", 32'(b.resp_vld), 0);
      chk("reset resp", 32'(b.resp), 0);

      // Fill the whole memory; ptr+size lands exactly on the depth, which is legal.
      wq.delete();
      for (int i = 0; i < 256; i++) wq.push_back($urandom);
      run_check("fill", 4'h0, 4'h1, 8'h01, 16'd256, 16'hA500, 0, 1'b1, 8'h10);

      foreach (tbl[k]) begin
         wq.delete();
         for (int i = 0; i < ((tbl[k].op == 8'h01) ? int'(tbl[k].size) : 2); i++)
            wq.push_back((k == 0) ? 32'hA0 + 32'(i) : $urandom);
         run_check($sformatf("tbl%0d", k), tbl[k].sel, tbl[k].id, tbl[k].op, tbl[k].size,
                   tbl[k].ext, tbl[k].rdy_mode, tbl[k].exp_got, tbl[k].exp_resp);
      end
      chk("first read word", ref_mem[8'h12], 32'hA2);

      // Back-to-back: a second command with en held high must not start.
      wq.delete(); wq.push_back(32'h1111_2222);
      do_cmd(4'h0, 4'h5, 8'h01, 16'd1, 16'h0040, 0, 40, 1'b1, got, rv);
      chk("b2b first resp", 32'(rv), 32'h50);
      ref_mem[8'h40] = 32'h1111_2222;
      b.l3_op = 8'h02; b.l3_id = 4'h6; b.l3_rd_rdy = 1'b1; b.l3_wd_vld = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         if (b.resp_vld || b.l3_rd_vld || b.l3_wd_rdy) seen = 1'b1;
         @(negedge clk);
      end
      chk("b2b no restart", 32'(seen), 0);
      b.l3_en = 1'b0; @(negedge clk);
      wq.delete();
      run_check("b2b second", 4'h0, 4'h6, 8'h02, 16'd1, 16'h0040, 0, 1'b1, 8'h60);

      // Abort a 4-word write after 2 words.
      wq.delete();
      for (int i = 0; i < 4; i++) wq.push_back($urandom);
      b.l3_sel = 4'h0; b.l3_id = 4'h8; b.l3_op = 8'h01; b.l3_size = 16'd4; b.l3_extend = 16'h0050;
      b.l3_en = 1'b1; b.resp_rdy = 1'b1; wi = 0;
      for (int c = 0; c < 40 && wi < 2; c++) begin
         b.l3_wd_vld = 1'b1; b.l3_wd = wq[wi];
         if (b.l3_wd_rdy) wi++;
         @(negedge clk);
      end
      chk("abort words sent", wi, 2);
      b.l3_en = 1'b0; b.l3_wd = wq[2];
      @(negedge clk);
      chk("abort wd_rdy", 32'(b.l3_wd_rdy), 0);
      seen = 1'b0;
      repeat (4) begin
         if (b.resp_vld) seen = 1'b1;
         @(negedge clk);
      end
      chk("abort no resp", 32'(seen), 0);
      b.l3_wd_vld = 1'b0;
      ref_mem[8'h50] = wq[0]; ref_mem[8'h51] = wq[1];
      run_check("abort readback", 4'h0, 4'h8, 8'h02, 16'd4, 16'h0050, 0, 1'b1, 8'h80);

      // Soft clear while a read word is stalled.
      b.l3_id = 4'h1; b.l3_op = 8'h02; b.l3_size = 16'd4; b.l3_extend = 16'h0010;
      b.l3_rd_rdy = 1'b0; b.l3_en = 1'b1;
      for (int c = 0; c < 20 && !b.l3_rd_vld; c++) @(negedge clk);
      chk("clr rd_vld before", 32'(b.l3_rd_vld), 1);
      clr = 1'b1; @(negedge clk); clr = 1'b0;
      chk("clr rd_vld after", 32'(b.l3_rd_vld), 0);
      chk("clr resp_vld", 32'(b.resp_vld), 0);
      chk("clr rd", b.l3_rd, 0);
      b.l3_en = 1'b0; @(negedge clk); @(negedge clk);

      // Reset while a status byte waits for ready.
      b.l3_id = 4'hC; b.l3_op = 8'h77; b.l3_size = 16'd1; b.l3_extend = 16'h0000;
      b.resp_rdy = 1'b0; b.l3_en = 1'b1;
      for (int c = 0; c < 20 && !b.resp_vld; c++) @(negedge clk);
      chk("rst resp before", {23'd0, b.resp_vld, b.resp}, 32'h1C1);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      chk("rst resp_vld after", 32'(b.resp_vld), 0);
      chk("rst resp after", 32'(b.resp), 0);
      b.l3_en = 1'b0; b.resp_rdy = 1'b1; @(negedge clk);

      for (int k = 0; k < 40; k++) begin
         sel = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         id  = 4'($urandom);
         case ($urandom_range(0, 4))
            0, 1:    op = 8'h01;
            2, 3:    op = 8'h02;
            default: op = 8'($urandom_range(3, 255));
         endcase
         size = 16'($urandom_range(0, 8));
         if ($urandom_range(0, 7) == 0) size = 16'($urandom_range(9, 300));
         ext = {8'($urandom), ($urandom_range(0, 2) == 0) ? 8'($urandom_range(248, 255))
                                                         : 8'($urandom)};
         wq.delete();
         for (int i = 0; i < ((op == 8'h01) ? int'(size) : 2); i++) wq.push_back($urandom);
         code = exp_code(op, size, ext);
         run_check($sformatf("rand%0d", k), sel, id, op, size, ext, $urandom_range(0, 1),
                   sel == 4'h0, {id, code});
      end

      chk("read word held while stalled", stall_err, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
